// File: rtl/pixel_histogram.sv
`default_nettype none
// ============================================================================
// Module   : pixel_histogram
// Purpose  : Per-frame intensity histogram of a 2-pixel/clock RAW stream,
//            streamed out bin by bin (clear-on-read) after each frame ends.
// Revision : 1.0  initial release
// ============================================================================
module pixel_histogram #(
  parameter int PIX_W    = 10,
  parameter int BIN_BITS = 6,
  parameter int COUNT_W  = 24
) (
  input  logic                 clk_pixel_i,
  input  logic                 reset_pixel_n_i,
  input  logic                 enable_i,
  input  logic [2*PIX_W-1:0]   pd_i,
  input  logic                 lv_i,
  input  logic                 fv_i,
  input  logic [1:0]           p_odd_i,
  output logic                 hist_valid_o,
  input  logic                 hist_ready_i,
  output logic [BIN_BITS-1:0]  hist_bin_o,
  output logic [COUNT_W-1:0]   hist_data_o,
  output logic                 hist_last_o,
  output logic                 frame_done_o,
  output logic                 busy_o,
  output logic [7:0]           drop_cnt_o
);

  localparam int BINS = 2**BIN_BITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DUMP  = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_fv_q;
  logic                 r_seen_low;
  logic [BIN_BITS-1:0]  r_idx;
  logic [COUNT_W-1:0]   r_bin [BINS];
  logic                 r_frame_done;
  logic [7:0]           r_drop;

  logic                 w_start;
  logic                 w_end;
  logic                 w_pix;
  logic                 w_lane1;
  logic                 w_dump;
  logic                 w_unused;
  logic [BIN_BITS-1:0]  w_bin0;
  logic [BIN_BITS-1:0]  w_bin1;
  logic [1:0]           w_inc  [BINS];
  logic [COUNT_W:0]     w_sum  [BINS];
  logic [COUNT_W-1:0]   w_next [BINS];

  // A frame already in progress when reset releases must not count as a start.
  assign w_start  = fv_i & ~r_fv_q & r_seen_low;
  assign w_end    = ~fv_i & r_fv_q;
  assign w_pix    = fv_i & lv_i;
  assign w_lane1  = ~p_odd_i[0];
  assign w_bin0   = pd_i[PIX_W-1 -: BIN_BITS];
  assign w_bin1   = pd_i[2*PIX_W-1 -: BIN_BITS];
  assign w_dump   = (r_state == S_DUMP);
  assign w_unused = ^{p_odd_i[1], pd_i[PIX_W-BIN_BITS-1:0],
                      pd_i[2*PIX_W-BIN_BITS-1:PIX_W]};

  // Both lanes landing in one bin add 2; the extra sum bit flags saturation.
  always_comb begin
    for (int k = 0; k < BINS; k++) begin
      w_inc[k]  = 2'(w_bin0 == BIN_BITS'(k)) +
                  2'(w_lane1 && (w_bin1 == BIN_BITS'(k)));
      w_sum[k]  = {1'b0, r_bin[k]} + (COUNT_W+1)'(w_inc[k]);
      w_next[k] = w_sum[k][COUNT_W] ? {COUNT_W{1'b1}} : w_sum[k][COUNT_W-1:0];
    end
  end

  always_ff @(posedge clk_pixel_i or negedge reset_pixel_n_i) begin
    if (!reset_pixel_n_i) begin
      r_state      <= S_IDLE;
      r_fv_q       <= 1'b0;
      r_seen_low   <= 1'b0;
      r_idx        <= '0;
      r_frame_done <= 1'b0;
      r_drop       <= 8'd0;
      for (int k = 0; k < BINS; k++) begin
        r_bin[k] <= '0;
      end
    end else begin
      r_fv_q       <= fv_i;
      r_frame_done <= 1'b0;
      if (!fv_i) begin
        r_seen_low <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_start && enable_i) begin
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_pix) begin
            for (int k = 0; k < BINS; k++) begin
              r_bin[k] <= w_next[k];
            end
          end
          if (w_end) begin
            r_state <= S_DUMP;
            r_idx   <= '0;
          end
        end
        S_DUMP: begin
          if (w_start && (r_drop != 8'hFF)) begin
            r_drop <= r_drop + 8'd1;
          end
          if (hist_ready_i) begin
            r_bin[r_idx] <= '0;
            r_idx        <= r_idx + 1'b1;
            if (r_idx == {BIN_BITS{1'b1}}) begin
              r_state      <= S_IDLE;
              r_frame_done <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign hist_valid_o = w_dump;
  assign hist_bin_o   = w_dump ? r_idx : '0;
  assign hist_data_o  = w_dump ? r_bin[r_idx] : '0;
  assign hist_last_o  = w_dump & (r_idx == {BIN_BITS{1'b1}});
  assign frame_done_o = r_frame_done;
  assign busy_o       = (r_state != S_IDLE);
  assign drop_cnt_o   = r_drop;

endmodule
`default_nettype wire
